// File: rtl/umi_arbiter.sv
// umi_arbiter: packet-level round-robin arbiter sharing one UMI request port
// between N requesters. A grant is held for every beat of a packet, where the
// packet length is decoded from cmd[11:8] of the first beat (beats = len+1).
// Output path is a combinational mux of the granted requester.
// Optional feature macro: UMI_ARB_FIXEDPRI_EN adds the fixedpri input, which
// selects lowest-index-wins arbitration while the pointer keeps advancing.
module umi_arbiter #(
  parameter int N  = 4,
  parameter int DW = 256,
  parameter int CW = 32
) (
  input  logic            clk,
  input  logic            reset,
`ifdef UMI_ARB_FIXEDPRI_EN
  input  logic            fixedpri,
`endif
  input  logic [N-1:0]    in_valid,
  input  logic [N*CW-1:0] in_cmd,
  input  logic [N*DW-1:0] in_packet,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [CW-1:0]   out_cmd,
  output logic [DW-1:0]   out_packet,
  input  logic            out_ready,
  output logic [N-1:0]    out_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          first_q, first_d;

  logic [PW-1:0] ptr_adv;
  logic [PW-1:0] arb_ptr;
  logic [N-1:0]  winner;
  logic          xfer;
  logic          last_beat;

  // Round-robin pick: first requester at or above ptr, wrapping to the bottom.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req,
                                           input logic [PW-1:0] ptr);
    logic [N-1:0] pick;
    logic         found;
    int           idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic logic [PW-1:0] onehot_idx(input logic [N-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      if (oh[k]) idx = PW'(k);
    end
    return idx;
  endfunction

  // Pointer one past the given index, wrapping N-1 back to 0.
  function automatic logic [PW-1:0] ptr_wrap(input logic [PW-1:0] idx);
    if (idx == PW'(N - 1)) return '0;
    else                   return idx + PW'(1);
  endfunction

  // Output mux and handshake signals driven straight from the current grant.
  always_comb begin
    out_cmd    = '0;
    out_packet = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_q[k]) begin
        out_cmd    = out_cmd    | in_cmd[k*CW +: CW];
        out_packet = out_packet | in_packet[k*DW +: DW];
      end
    end
    out_valid = |(in_valid & gnt_q);
    in_ready  = gnt_q & {N{out_ready && (state_q == GRANT)}};
    out_gnt   = gnt_q;
    xfer      = out_valid & out_ready;
  end

  // Arbitration winner; in GRANT it is only consumed on the last beat, so the
  // search starts from the pointer as it will be after this packet completes.
  always_comb begin
    ptr_adv = ptr_wrap(onehot_idx(gnt_q));
    arb_ptr = (state_q == GRANT) ? ptr_adv : ptr_q;
`ifdef UMI_ARB_FIXEDPRI_EN
    if (fixedpri) arb_ptr = '0;
`endif
    winner = rr_pick(in_valid, arb_ptr);
  end

  // Next-state logic: grant selection, beat counting and pointer update.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    last_beat = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        first_d = 1'b1;
        cnt_d   = '0;
        if (|in_valid) begin
          state_d = GRANT;
          gnt_d   = winner;
        end
      end
      GRANT: begin
        if (xfer) begin
          // cnt holds the beats still to come after the current one; the
          // length field is only trusted on the first beat of a packet.
          if (first_q) begin
            cnt_d     = out_cmd[11:8];
            first_d   = 1'b0;
            last_beat = (out_cmd[11:8] == 4'd0);
          end else begin
            cnt_d     = cnt_q - 4'd1;
            last_beat = (cnt_q == 4'd1);
          end
          if (last_beat) begin
            ptr_d   = ptr_adv;
            first_d = 1'b1;
            cnt_d   = '0;
            if (|in_valid) begin
              gnt_d = winner;
            end else begin
              state_d = IDLE;
              gnt_d   = '0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_umi_arbiter.sv
// Directed bench for umi_arbiter with hand-computed grant sequences.
module tb_umi_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*CW-1:0] in_cmd;
  logic [N*DW-1:0] in_packet;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [CW-1:0]   out_cmd;
  logic [DW-1:0]   out_packet;
  logic            out_ready;
  logic [N-1:0]    out_gnt;
`ifdef UMI_ARB_FIXEDPRI_EN
  logic            fixedpri;
`endif

  int n_chk = 0;
  int n_err = 0;

  umi_arbiter #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef UMI_ARB_FIXEDPRI_EN
    .fixedpri   (fixedpri),
`endif
    .in_valid   (in_valid),
    .in_cmd     (in_cmd),
    .in_packet  (in_packet),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_cmd    (out_cmd),
    .out_packet (out_packet),
    .out_ready  (out_ready),
    .out_gnt    (out_gnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_gnt(input string tag, input logic [N-1:0] g, input logic v);
    check({tag, "_gnt"}, 64'(out_gnt), 64'(g));
    check({tag, "_vld"}, 64'(out_valid), 64'(v));
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] len,
                         input logic [DW-1:0] data);
    in_valid[i]            = v;
    in_cmd[i*CW +: CW]     = {20'h0, len, 8'h01};
    in_packet[i*DW +: DW]  = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = '0;
    tick();
    reset    = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_cmd    = '0;
    in_packet = '0;
    out_ready = 1'b1;
`ifdef UMI_ARB_FIXEDPRI_EN
    fixedpri  = 1'b0;
`endif

    // Reset dominates a pending request
    set_req(0, 1'b1, 4'd0, 32'hA0);
    tick();
    tick();
    #1;
    expect_gnt("rst", 4'b0000, 1'b0);
    check("rst_rdy", 64'(in_ready), 64'h0);
    reset    = 1'b0;
    in_valid = '0;

    // Test 1: req0/req1 single-beat packets alternate
    set_req(0, 1'b1, 4'd0, 32'hA0);
    set_req(1, 1'b1, 4'd0, 32'hB0);
    #1;
    expect_gnt("t1_idle", 4'b0000, 1'b0);
    tick(); #1;
    expect_gnt("t1_g0a", 4'b0001, 1'b1);
    check("t1_rdy0", 64'(in_ready), 64'h1);
    check("t1_pkt0", 64'(out_packet), 64'hA0);
    tick(); #1;
    expect_gnt("t1_g1a", 4'b0010, 1'b1);
    check("t1_pkt1", 64'(out_packet), 64'hB0);
    tick(); #1;
    expect_gnt("t1_g0b", 4'b0001, 1'b1);
    tick(); #1;
    expect_gnt("t1_g1b", 4'b0010, 1'b1);
    do_reset();

    // Test 2: req2 4-beat packet, req0 follows with no bubble
    set_req(2, 1'b1, 4'd3, 32'hC1);
    tick();
    set_req(0, 1'b1, 4'd0, 32'hA0);
    #1;
    expect_gnt("t2_b1", 4'b0100, 1'b1);
    check("t2_cmd", 64'(out_cmd), 64'h0000_0301);
    check("t2_pkt1", 64'(out_packet), 64'hC1);
    tick();
    set_req(2, 1'b1, 4'd0, 32'hC2);
    #1;
    expect_gnt("t2_b2", 4'b0100, 1'b1);
    check("t2_pkt2", 64'(out_packet), 64'hC2);
    tick();
    set_req(2, 1'b1, 4'd0, 32'hC3);
    #1;
    expect_gnt("t2_b3", 4'b0100, 1'b1);
    tick();
    set_req(2, 1'b1, 4'd0, 32'hC4);
    #1;
    expect_gnt("t2_b4", 4'b0100, 1'b1);
    check("t2_pkt4", 64'(out_packet), 64'hC4);
    tick();
    set_req(2, 1'b0, 4'd0, 32'h0);
    #1;
    expect_gnt("t2_next", 4'b0001, 1'b1);
    check("t2_pktA", 64'(out_packet), 64'hA0);
    do_reset();

    // Test 3: pointer at 3, req3 wins then wraps to req0
    set_req(2, 1'b1, 4'd0, 32'hC0);
    tick();
    set_req(3, 1'b1, 4'd0, 32'hD0);
    set_req(0, 1'b1, 4'd0, 32'hA0);
    #1;
    expect_gnt("t3_g2", 4'b0100, 1'b1);
    tick();
    set_req(2, 1'b0, 4'd0, 32'h0);
    #1;
    expect_gnt("t3_g3", 4'b1000, 1'b1);
    check("t3_pkt3", 64'(out_packet), 64'hD0);
    tick(); #1;
    expect_gnt("t3_g0", 4'b0001, 1'b1);
    check("t3_pkt0", 64'(out_packet), 64'hA0);
    do_reset();

    // Test 4: out_ready stall mid-packet, valid drop, exactly 4 beats
    set_req(1, 1'b1, 4'd3, 32'hB1);
    tick(); #1;
    expect_gnt("t4_g", 4'b0010, 1'b1);
    check("t4_rdy", 64'(in_ready), 64'h2);
    tick();
    set_req(1, 1'b1, 4'd3, 32'hB2);
    tick();
    set_req(1, 1'b1, 4'd3, 32'hB3);
    set_req(0, 1'b1, 4'd0, 32'hA0);
    out_ready = 1'b0;
    #1;
    expect_gnt("t4_stall0", 4'b0010, 1'b1);
    check("t4_rdy_stall0", 64'(in_ready), 64'h0);
    for (int s = 0; s < 5; s++) begin
      tick(); #1;
      expect_gnt($sformatf("t4_stall%0d", s + 1), 4'b0010, 1'b1);
      check($sformatf("t4_rdy_stall%0d", s + 1), 64'(in_ready), 64'h0);
    end
    out_ready = 1'b1;
    #1;
    check("t4_rdy_resume", 64'(in_ready), 64'h2);
    check("t4_pkt3", 64'(out_packet), 64'hB3);
    in_valid[1] = 1'b0;
    #1;
    expect_gnt("t4_drop", 4'b0010, 1'b0);
    tick();
    set_req(1, 1'b1, 4'd3, 32'hB3);
    #1;
    expect_gnt("t4_back", 4'b0010, 1'b1);
    tick();
    set_req(1, 1'b1, 4'd3, 32'hB4);
    #1;
    expect_gnt("t4_b4", 4'b0010, 1'b1);
    check("t4_pkt4", 64'(out_packet), 64'hB4);
    tick(); #1;
    expect_gnt("t4_after", 4'b0001, 1'b1);
    do_reset();

    // Test 5: reset on beat 2 of an 8-beat packet clears grant and pointer
    set_req(2, 1'b1, 4'd0, 32'hC0);
    tick();
    set_req(3, 1'b1, 4'd7, 32'hD1);
    #1;
    expect_gnt("t5_g2", 4'b0100, 1'b1);
    tick();
    set_req(2, 1'b0, 4'd0, 32'h0);
    #1;
    expect_gnt("t5_g3", 4'b1000, 1'b1);
    tick(); #1;
    expect_gnt("t5_b2", 4'b1000, 1'b1);
    reset = 1'b1;
    tick(); #1;
    expect_gnt("t5_rst", 4'b0000, 1'b0);
    check("t5_rst_rdy", 64'(in_ready), 64'h0);
    reset = 1'b0;
    set_req(1, 1'b1, 4'd0, 32'hB0);
    #1;
    expect_gnt("t5_idle", 4'b0000, 1'b0);
    tick(); #1;
    expect_gnt("t5_g1", 4'b0010, 1'b1);
    check("t5_pkt1", 64'(out_packet), 64'hB0);
    do_reset();

`ifdef UMI_ARB_FIXEDPRI_EN
    // Test 6: fixed priority keeps req0 granted, then alternation resumes
    fixedpri = 1'b1;
    set_req(0, 1'b1, 4'd0, 32'hA0);
    set_req(3, 1'b1, 4'd0, 32'hD0);
    tick(); #1;
    expect_gnt("t6_f0", 4'b0001, 1'b1);
    tick(); #1;
    expect_gnt("t6_f1", 4'b0001, 1'b1);
    tick(); #1;
    expect_gnt("t6_f2", 4'b0001, 1'b1);
    fixedpri = 1'b0;
    tick(); #1;
    expect_gnt("t6_rr3", 4'b1000, 1'b1);
    tick(); #1;
    expect_gnt("t6_rr0", 4'b0001, 1'b1);
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
